// File: rtl/plic_lite.sv
// plic_lite: lightweight PLIC arbitrating level-sensitive sources into one machine external interrupt,
// with a per-source gateway, priority/threshold filtering and a Wishbone claim/complete handshake.
module plic_lite #(
  parameter int NUM_SOURCES    = 8,
  parameter int PRIORITY_WIDTH = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SOURCES-1:0] sources_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [9:0]             wb_addr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   external_interrupt_o
);
  localparam int N = NUM_SOURCES;
  localparam int P = PRIORITY_WIDTH;
  logic [N:1] sync1_q, sync2_q, pend_q, pend_d, insvc_q, insvc_d, en_q, en_d, elig;
  logic [N:1][P-1:0] prio_q, prio_d;
  logic [P-1:0] thr_q, thr_d, best;
  logic [31:0] dat_q, rdata;
  logic ack_q;
  logic [4:0] win;
  logic [7:0] word;
  logic rd, wr, unused_ok;
  assign word = wb_addr_i[9:2];
  assign rd = wb_cyc_i & wb_stb_i & ~ack_q & ~wb_we_i;
  assign wr = wb_cyc_i & wb_stb_i & ~ack_q & wb_we_i;
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign external_interrupt_o = |elig;
  assign unused_ok = ^{wb_addr_i[1:0], wb_dat_i};
  // Descending scan with >= leaves the lowest ID on priority ties.
  always_comb begin
    elig = '0;
    win = '0;
    best = '0;
    for (int i = N; i >= 1; i--) begin
      elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && prio_q[i] >= best) begin
        win = 5'(i);
        best = prio_q[i];
      end
    end
  end
  always_comb begin
    rdata = '0;
    prio_d = prio_q;
    en_d = en_q;
    thr_d = thr_q;
    insvc_d = insvc_q;
    pend_d = pend_q | (sync2_q & ~insvc_q);
    for (int i = 1; i <= N; i++) begin
      if (word == 8'(i)) begin
        rdata = 32'(prio_q[i]);
        if (wr) prio_d[i] = wb_dat_i[P-1:0];
      end
      // A claim overrides a gateway set of the same ID on the same edge.
      if (rd && word == 8'h81 && win == 5'(i)) begin
        pend_d[i] = 1'b0;
        insvc_d[i] = 1'b1;
      end
      if (wr && word == 8'h81 && wb_dat_i[4:0] == 5'(i)) insvc_d[i] = 1'b0;
    end
    if (word == 8'h20) rdata = 32'({pend_q, 1'b0});
    if (word == 8'h40) begin
      rdata = 32'({en_q, 1'b0});
      if (wr) en_d = wb_dat_i[N:1];
    end
    if (word == 8'h80) begin
      rdata = 32'(thr_q);
      if (wr) thr_d = wb_dat_i[P-1:0];
    end
    if (word == 8'h81) rdata = 32'(win);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q <= '0;
      insvc_q <= '0;
      en_q <= '0;
      prio_q <= '0;
      thr_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
    end else begin
      sync1_q <= sources_i;
      sync2_q <= sync1_q;
      pend_q <= pend_d;
      insvc_q <= insvc_d;
      en_q <= en_d;
      prio_q <= prio_d;
      thr_q <= thr_d;
      dat_q <= rd ? rdata : '0;
      ack_q <= rd | wr;
    end
  end
endmodule

// File: doc/plic_lite.md
# plic_lite

Lightweight platform-level interrupt controller that arbitrates up to 31 level-sensitive external interrupt sources into the single `external_interrupt` input of the core's CSR unit. It runs a per-source gateway (pending/in-service tracking), priority/threshold filtering, and a memory-mapped claim/complete handshake. It sits on the core's Wishbone-style peripheral bus next to the timer block. Software in M-mode claims the winning source, services it, then completes it.

## Interface
- `NUM_SOURCES`, 8: number of sources, 1..31; source IDs are 1..NUM_SOURCES and ID 0 means "none".
- `PRIORITY_WIDTH`, 3: bits per priority and threshold field.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0); clears all state.
- `sources` input NUM_SOURCES: raw level interrupt lines; bit i-1 is source ID i; asynchronous to `clock`.
- `wb_cyc`, `wb_stb`, `wb_we` input 1 each: bus cycle, strobe, write enable.
- `wb_addr` input 10: byte address, word aligned; bits [1:0] ignored.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: read data, valid while `wb_ack` is high.
- `wb_ack` output 1: one-cycle transfer acknowledge.
- `external_interrupt` output 1: request to the CSR unit (`mip.MEI`).

## Operation
- Register map, 32-bit words:
  - 0x000+4·i: `priority[i]`, RW, low PRIORITY_WIDTH bits. i=0 reads 0 and ignores writes.
  - 0x080: `pending`, RO. Bit i is pending[i]; bit 0 reads 0.
  - 0x100: `enable`, RW. Bit i enables source i; bit 0 is hardwired 0; bits above NUM_SOURCES read 0.
  - 0x200: `threshold`, RW.
  - 0x204: `claim/complete`. A read claims; a write completes.
- Unmapped or out-of-range addresses are acknowledged; reads return 0 and writes are ignored.
- Synchronizer: each source passes through 2 flops, giving `src_s`.
- Gateway per source i: pending[i] is set when `src_s[i]` is 1, in_service[i] is 0 and pending[i] is 0. Pending is not cleared by the source dropping; only a claim clears it.
- Eligible(i) = pending[i] & enable[i] & (priority[i] > threshold). Priority 0 is therefore never eligible.
- `external_interrupt` = OR over all Eligible(i). It is a combinational function of registered state only.
- Winner = the eligible ID with the highest priority; ties go to the lowest ID. If nothing is eligible, the winner is 0.
- Claim (read of 0x204):
  - `wb_dat_o` returns the winner ID.
  - On the same edge, pending[winner] is cleared and in_service[winner] is set.
  - If the winner is 0, there are no side effects.
- Complete (write of 0x204):
  - If `wb_dat_i[4:0]` is a valid ID with in_service set, in_service for that ID clears.
  - Otherwise the write is ignored.
- A source with in_service set cannot re-pend until it is completed.

## Timing
- Reset values: all priority, enable, threshold, pending and in_service are 0. Synchronizer flops are 0, `wb_ack`=0, `wb_dat_o`=0, `external_interrupt`=0.
- Bus transfers:
  - A request is `wb_cyc & wb_stb & !wb_ack`.
  - `wb_ack` rises on the edge after the request is seen and stays high for exactly 1 cycle. The master must drop `wb_stb` or present a new request after the ack.
  - Read data is registered and presented with the ack.
  - All write effects and claim side effects occur on the edge that raises `wb_ack`.
- Interrupt latency: a source rising before edge k appears in pending, and `external_interrupt` rises, after edge k+2 (3 edges).
- Winner and read data are sampled at the ack edge. A source pending on that same edge does not win that claim.
- Simultaneous claim of ID i and gateway set of ID i on the same edge: the claim wins. Result: pending=0, in_service=1.
- Complete and re-pend: after a complete edge for ID i with `src_s[i]` still high, pending[i] sets on the next edge.
- Register writes take effect for `external_interrupt` in the cycle after the ack edge.
- Reset asserted mid-transfer: `wb_ack` drops immediately (asynchronously), the transfer is lost, and all state clears.

## Test plan
- Reset with sources=0xFF: all registers read 0 and `external_interrupt`=0. After reset release, pending reads 0x1FE while enable=0 and IRQ stays 0.
- priority[3]=2, enable=0x08, threshold=1; raise source 3:
  - IRQ high 3 edges later.
  - Claim reads 3, pending bit 3 clears and IRQ drops.
  - Source held high, no re-pend until a write of 3 to 0x204; pending bit 3 sets 1 edge after that complete's ack.
- Sources 2 and 5 both priority 4, source 6 priority 7, all enabled:
  - Claims return 6, then 2, then 5, then 0.
- threshold=4 with priority[1]=4: source 1 pending, IRQ=0, claim returns 0. Set threshold=3 and IRQ rises the cycle after the ack.
- Complete with ID 7 (not in service), ID 0, and ID 31 (NUM_SOURCES=8): no state change and all transfers acked in 1 cycle.
- Assert reset mid-read: `wb_ack` goes low asynchronously, in_service clears, and after release a re-raised source re-pends.
